// File: rtl/trisc2_pkg.sv
// Shared definitions for the TRISC2 run-mode sequencer: widths, opcodes, state encoding.
package trisc2_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JZ  = 4'd6;
  localparam logic [3:0] OP_HLT = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_W,
    ST_DECODE,
    ST_READ,
    ST_READ_W,
    ST_WRITE,
    ST_HALT
  } state_e;

endpackage

// File: rtl/trisc2_alu.sv
// Combinational accumulator datapath for LDA/ADD/SUB; carry is the 9th sum bit or the borrow.
module trisc2_alu
  import trisc2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = acc;
    carry  = 1'b0;
    case (opcode)
      OP_LDA: result = operand;
      OP_ADD: {carry, result} = {1'b0, acc} + {1'b0, operand};
      OP_SUB: begin
        result = acc - operand;
        carry  = (acc < operand);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/trisc2_control.sv
// TRISC2 fetch/decode/execute sequencer: owns PC, MAR, IR, ACC and drives the run-mode RAM port.
module trisc2_control
  import trisc2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start_stop,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_en,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] acc,
  output logic              zf,
  output logic              cf,
  output logic              running,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, acc_q, acc_d;
  logic              cf_q, cf_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand_addr;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  state_e            boundary_state;

  assign opcode         = ir_q[DATA_W-1 -: 4];
  assign operand_addr   = ir_q[ADDR_W-1:0];
  // Instruction boundary: a stop request only takes effect here, never mid-access.
  assign boundary_state = start_stop ? ST_FETCH : ST_IDLE;

  trisc2_alu #(.DATA_W(DATA_W)) u_alu (
    .acc     (acc_q),
    .operand (mem_q),
    .opcode  (opcode),
    .result  (alu_result),
    .carry   (alu_carry)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mar_d    = mar_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    cf_d     = cf_q;
    mem_addr = '0;
    mem_en   = 1'b0;
    mem_wren = 1'b0;
    case (state_q)
      ST_IDLE: if (start_stop) state_d = ST_FETCH;
      ST_FETCH: begin
        mem_addr = pc_q;
        mem_en   = 1'b1;
        state_d  = ST_FETCH_W;
      end
      ST_FETCH_W: begin
        ir_d    = mem_q;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        mar_d   = operand_addr;
        state_d = boundary_state;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: state_d = ST_READ;
          OP_STA: state_d = ST_WRITE;
          OP_JMP: pc_d = operand_addr;
          OP_JZ:  if (acc_q == '0) pc_d = operand_addr;
          OP_HLT: state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_READ: begin
        mem_addr = mar_q;
        mem_en   = 1'b1;
        state_d  = ST_READ_W;
      end
      ST_READ_W: begin
        acc_d   = alu_result;
        if (opcode == OP_ADD || opcode == OP_SUB) cf_d = alu_carry;
        state_d = boundary_state;
      end
      ST_WRITE: begin
        mem_addr = mar_q;
        mem_en   = 1'b1;
        mem_wren = 1'b1;
        state_d  = boundary_state;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      cf_q    <= cf_d;
    end
  end

  assign mem_data = acc_q;
  assign pc       = pc_q;
  assign mar      = mar_q;
  assign ir       = ir_q;
  assign acc      = acc_q;
  assign zf       = (acc_q == '0);
  assign cf       = cf_q;
  assign running  = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_trisc2_control.sv
// Directed bench for trisc2_control: a 16x8 synchronous RAM model plus hand-computed expectations.
module tb_trisc2_control;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start_stop = 1'b0;
  logic [7:0] mem_q = 8'h00;
  logic [3:0] mem_addr, pc, mar;
  logic [7:0] mem_data, ir, acc;
  logic       mem_en, mem_wren, zf, cf, running, halted;

  logic [7:0] ram [16];
  logic       ld_en = 1'b0;
  logic [3:0] ld_addr = 4'h0;
  logic [7:0] ld_data = 8'h00;
  int         wr_count = 0;
  int         en_count = 0;
  logic [3:0] last_wr_addr = 4'h0;
  logic [7:0] last_wr_data = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc;
  int wr_base;
  int en_base;

  trisc2_control #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock      (clock),
    .clear      (clear),
    .start_stop (start_stop),
    .mem_q      (mem_q),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_en     (mem_en),
    .mem_wren   (mem_wren),
    .pc         (pc),
    .mar        (mar),
    .ir         (ir),
    .acc        (acc),
    .zf         (zf),
    .cf         (cf),
    .running    (running),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  // RAM: read data registered one cycle after a read strobe; bench loads take priority.
  always @(posedge clock) begin
    if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (mem_en && mem_wren) begin
      ram[mem_addr] <= mem_data;
      wr_count      <= wr_count + 1;
      last_wr_addr  <= mem_addr;
      last_wr_data  <= mem_data;
    end
    if (mem_en) en_count <= en_count + 1;
    if (mem_en && !mem_wren) mem_q <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick(1);
    ld_en   = 1'b0;
  endtask

  task automatic prep();
    clear      = 1'b1;
    start_stop = 1'b0;
    for (int i = 0; i < 16; i++) load(4'(i), 8'h00);
  endtask

  task automatic release_run();
    clear      = 1'b0;
    start_stop = 1'b1;
  endtask

  task automatic run_to_halt(output int n);
    n = 0;
    while (!halted && n < 200) begin
      tick(1);
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    #2;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_mar", 32'(mar), 32'h0);
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_acc", 32'(acc), 32'h0);
    check("rst_cf", 32'(cf), 32'h0);
    check("rst_zf", 32'(zf), 32'h1);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_wren", 32'(mem_wren), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);

    // ---- main program: LDA 10, ADD 11, STA 12, HLT ----
    prep();
    load(4'h0, 8'h1A); load(4'h1, 8'h2B); load(4'h2, 8'h4C); load(4'h3, 8'h70);
    load(4'hA, 8'h05); load(4'hB, 8'hFE);
    wr_base = wr_count;
    release_run();
    tick(1);
    check("main_fetch0_en", 32'(mem_en), 32'h1);
    check("main_fetch0_addr", 32'(mem_addr), 32'h0);
    check("main_running", 32'(running), 32'h1);
    tick(10);
    check("main_add_acc", 32'(acc), 32'h03);
    check("main_add_cf", 32'(cf), 32'h1);
    check("main_add_zf", 32'(zf), 32'h0);
    check("main_fetch2_addr", 32'(mem_addr), 32'h2);
    check("main_pc_before_sta", 32'(pc), 32'h2);
    tick(3);
    check("main_write_wren", 32'(mem_wren), 32'h1);
    check("main_write_en", 32'(mem_en), 32'h1);
    check("main_write_addr", 32'(mem_addr), 32'hC);
    check("main_write_data", 32'(mem_data), 32'h03);
    run_to_halt(n_cyc);
    check("main_cycles_to_halt", 32'(13 + n_cyc), 32'd17);
    check("main_write_count", 32'(wr_count - wr_base), 32'd1);
    check("main_last_wr_addr", 32'(last_wr_addr), 32'hC);
    check("main_last_wr_data", 32'(last_wr_data), 32'h03);
    check("main_halt_pc", 32'(pc), 32'h4);
    check("main_halt_running", 32'(running), 32'h0);
    start_stop = 1'b0;
    tick(2);
    start_stop = 1'b1;
    tick(2);
    check("halt_sticky", 32'(halted), 32'h1);
    check("halt_no_access", 32'(mem_en), 32'h0);
    check("halt_pc_hold", 32'(pc), 32'h4);

    // ---- asynchronous clear during the READ of an ADD ----
    prep();
    load(4'h0, 8'h1A); load(4'h1, 8'h2B); load(4'hA, 8'h05); load(4'hB, 8'h05);
    release_run();
    tick(9);
    check("midread_en", 32'(mem_en), 32'h1);
    check("midread_addr", 32'(mem_addr), 32'hB);
    check("midread_acc", 32'(acc), 32'h05);
    #1 clear = 1'b1;
    #1;
    check("async_pc", 32'(pc), 32'h0);
    check("async_acc", 32'(acc), 32'h0);
    check("async_ir", 32'(ir), 32'h0);
    check("async_mar", 32'(mar), 32'h0);
    check("async_mem_en", 32'(mem_en), 32'h0);
    check("async_mem_addr", 32'(mem_addr), 32'h0);
    check("async_running", 32'(running), 32'h0);
    wr_base = wr_count;
    tick(1);
    clear = 1'b0;
    tick(1);
    check("rerun_fetch_en", 32'(mem_en), 32'h1);
    check("rerun_fetch_addr", 32'(mem_addr), 32'h0);
    check("rerun_no_wren", 32'(mem_wren), 32'h0);
    check("rerun_no_write", 32'(wr_count - wr_base), 32'd0);

    // ---- SUB with borrow ----
    prep();
    load(4'h0, 8'h1A); load(4'h1, 8'h3B); load(4'h2, 8'h70);
    load(4'hA, 8'h02); load(4'hB, 8'h05);
    release_run();
    run_to_halt(n_cyc);
    check("sub_acc", 32'(acc), 32'hFD);
    check("sub_cf", 32'(cf), 32'h1);
    check("sub_pc", 32'(pc), 32'h3);

    // ---- JZ taken / not taken, JMP and PC wrap ----
    prep();
    load(4'h0, 8'h69); load(4'h9, 8'h1E); load(4'hA, 8'h6C); load(4'hB, 8'h5F);
    load(4'hE, 8'h01); load(4'hF, 8'h70);
    release_run();
    tick(1);
    tick(3);
    check("jz_taken_pc", 32'(pc), 32'h9);
    check("jz_taken_fetch", 32'(mem_addr), 32'h9);
    check("jz_taken_mar", 32'(mar), 32'h9);
    tick(5);
    check("jz_lda_acc", 32'(acc), 32'h01);
    check("jz_lda_fetch", 32'(mem_addr), 32'hA);
    tick(3);
    check("jz_not_taken_pc", 32'(pc), 32'hB);
    check("jz_not_taken_fetch", 32'(mem_addr), 32'hB);
    check("jz_not_taken_acc", 32'(acc), 32'h01);
    tick(3);
    check("jmp_pc", 32'(pc), 32'hF);
    check("jmp_fetch", 32'(mem_addr), 32'hF);
    run_to_halt(n_cyc);
    check("wrap_cycles", 32'(n_cyc), 32'd3);
    check("wrap_pc", 32'(pc), 32'h0);

    // ---- stop during FETCH_W of LDA, resume, undefined opcode ----
    prep();
    load(4'h0, 8'h1D); load(4'h1, 8'hA3); load(4'h2, 8'h70); load(4'hD, 8'h5A);
    wr_base = wr_count;
    release_run();
    tick(2);
    start_stop = 1'b0;
    tick(3);
    check("stop_lda_inflight", 32'(running), 32'h1);
    tick(1);
    check("stop_lda_acc", 32'(acc), 32'h5A);
    check("stop_idle_running", 32'(running), 32'h0);
    check("stop_idle_pc", 32'(pc), 32'h1);
    en_base = en_count;
    tick(4);
    check("stop_no_access", 32'(en_count - en_base), 32'd0);
    check("stop_still_idle", 32'(running), 32'h0);
    start_stop = 1'b1;
    tick(1);
    check("resume_fetch_addr", 32'(mem_addr), 32'h1);
    check("resume_fetch_en", 32'(mem_en), 32'h1);
    tick(3);
    check("undef_pc", 32'(pc), 32'h2);
    check("undef_mar", 32'(mar), 32'h3);
    check("undef_ir", 32'(ir), 32'hA3);
    check("undef_acc", 32'(acc), 32'h5A);
    check("undef_next_fetch", 32'(mem_addr), 32'h2);
    check("undef_no_write", 32'(wr_count - wr_base), 32'd0);
    run_to_halt(n_cyc);
    check("undef_halt_pc", 32'(pc), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trisc2_control.md
Name: trisc2_control

Overview:
- Fetch/decode/execute sequencer for the TRISC2 accumulator machine.
- Sits directly upstream of the TRISC2 RAM path and drives the run-mode (Mode=0) side of the RAM muxes: address, data, RAM clock-enable and write-enable.
- Holds PC, MAR, IR and ACC, and exposes PC and MAR for the hex displays.
- Program load (Mode=1) stays outside this block; this block only runs the program in RAM.

Parameters:
- ADDR_W, 4, RAM address width (PC/MAR width); 16-word RAM.
- DATA_W, 8, RAM word / IR / ACC width.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- start_stop  in  1  run request level; 1 = run, 0 = stop at next instruction boundary.
- mem_q  in  DATA_W  RAM read data; valid the cycle after mem_en with wren=0.
- mem_addr  out  ADDR_W  RAM address (feeds ramAddress).
- mem_data  out  DATA_W  RAM write data (feeds MDI); always equals ACC.
- mem_en  out  1  RAM access strobe (C4 equivalent).
- mem_wren  out  1  RAM write enable (C5 equivalent); only asserted together with mem_en.
- pc  out  ADDR_W  program counter.
- mar  out  ADDR_W  memory address register.
- ir  out  DATA_W  instruction register; [7:4] opcode, [3:0] operand address.
- acc  out  DATA_W  accumulator.
- zf  out  1  ACC==0, combinational from ACC.
- cf  out  1  carry from last ADD (carry-out) or SUB (1 = borrow).
- running  out  1  1 in any state except IDLE/HALT.
- halted  out  1  1 in HALT.

Behaviour:
- Reset (async, any state, mid-instruction included):
  - state=IDLE.
  - pc, mar, ir, acc, cf = 0.
  - mem_en, mem_wren = 0; mem_addr = 0.
  - No RAM write may be issued in the cycle clear deasserts.
- Opcodes:
  - 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 JMP, 6 JZ, 7 HLT.
  - 8-15 execute as NOP.
- States: IDLE, FETCH, FETCH_W, DECODE, READ, READ_W, WRITE, HALT.
- IDLE: outputs quiet; start_stop=1 -> FETCH.
- FETCH: mem_addr=pc, mem_en=1 -> FETCH_W.
- FETCH_W: ir<=mem_q; pc<=pc+1 (15 wraps to 0) -> DECODE.
- DECODE: mar<=ir[3:0], then:
  - LDA/ADD/SUB -> READ.
  - STA -> WRITE.
  - JMP: pc<=ir[3:0].
  - JZ: pc<=ir[3:0] only if acc==0; acc unchanged.
  - HLT -> HALT.
  - NOP/undefined: no register change.
  - JMP, JZ and NOP/undefined go to the boundary.
- READ: mem_addr=mar, mem_en=1 -> READ_W.
- READ_W, result written into acc, then boundary:
  - LDA: acc<=mem_q; cf unchanged.
  - ADD: {cf,acc}<=acc+mem_q, 9-bit.
  - SUB: acc<=acc-mem_q mod 256; cf<=(acc<mem_q).
- WRITE: mem_addr=mar, mem_data=acc, mem_en=1, mem_wren=1 for exactly one cycle -> boundary.
- Boundary: next state = FETCH if start_stop=1, else IDLE.
  - Dropping start_stop mid-instruction always completes that instruction; stop is never abandoned mid-access.
- HALT: leave only via clear; start_stop ignored.
- Instruction latency in cycles:
  - NOP/JMP/JZ/undefined: 3.
  - STA: 4.
  - LDA/ADD/SUB: 5.
- mem_en/mem_wren/mem_addr are registered-state decodes: glitch-free, one cycle per access.

Decomposition:
- trisc2_pkg holds:
  - opcode constants OP_NOP..OP_HLT.
  - state enum/encoding.
  - ADDR_W/DATA_W defaults.
- One sub-module trisc2_alu (combinational): inputs acc, operand, opcode; outputs result and carry for LDA/ADD/SUB.
- Sequencer FSM and registers live in trisc2_control.

Test Plan:
- Reset mid-READ (clear at cycle 3 of ADD) -> pc=0, acc=0, ir=0, mem_en=0 immediately (async); after release with start_stop=1, first FETCH at addr 0.
- RAM[0]=0x1A, [1]=0x2B, [2]=0x4C, [3]=0x70, [10]=0x05, [11]=0xFE, start_stop=1:
  - acc=0x03 and cf=1 after the ADD.
  - One write cycle addr 0xC, data 0x03.
  - halted=1 with pc=4.
  - 17 cycles from leaving IDLE to HALT.
- SUB borrow: acc=0x02 via LDA, then SUB of 0x05 -> acc=0xFD, cf=1.
- JZ taken vs not:
  - acc=0: 0x69 -> pc=9.
  - acc=0x01: JZ -> pc=old+1.
  - JMP 0x5F -> pc=0xF; fetch at 0xF then pc wraps to 0.
- start_stop dropped during FETCH_W of an LDA:
  - LDA completes (acc loaded, 5 cycles).
  - Then IDLE; running=0, no further mem_en.
  - Reasserting start_stop resumes at the saved pc.
- Undefined opcode 0xA3 -> behaves as NOP: 3 cycles, pc+1; acc, mar side effects only (mar=3); no RAM write.
